// File: rtl/ubc_pkg.sv
// rtl/ubc_pkg.sv - shared defaults, mode encoding and modulus-width helper for ubc_param
package ubc_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_STEP_W = 4;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } ubc_mode_e;

  // The modulus limit+1 needs one bit more than the count itself.
  function automatic int mod_width(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/ubc_step_unit.sv
// rtl/ubc_step_unit.sv - combinational next count and terminal-count for one enabled step
module ubc_step_unit
  import ubc_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STEP_W = DEFAULT_STEP_W
) (
  input  logic [WIDTH-1:0]  i_out,
  input  logic [WIDTH-1:0]  i_limit,
  input  logic [STEP_W-1:0] i_step,
  input  logic              i_is_up,
  input  ubc_mode_e         i_mode,
  output logic [WIDTH-1:0]  o_next,
  output logic              o_tc
);

  localparam int MW = mod_width(WIDTH);

  logic [MW-1:0] w_cur;
  logic [MW-1:0] w_lim;
  logic [MW-1:0] w_mod;
  logic [MW-1:0] w_step;
  logic [MW-1:0] w_s;
  logic [MW-1:0] w_sum;
  logic [MW-1:0] w_room;

  assign w_cur  = {1'b0, i_out};
  assign w_lim  = {1'b0, i_limit};
  assign w_mod  = w_lim + MW'(1);
  assign w_step = MW'(i_step);
  assign w_s    = (w_step > w_mod) ? w_mod : w_step;
  assign w_sum  = w_cur + w_s;
  // Wrap-down result is out + (M - s); M >= s keeps this inside MW bits.
  assign w_room = w_mod - w_s;

  always_comb begin
    o_next = i_out;
    o_tc   = 1'b0;
    if (w_s != '0) begin
      if (w_cur > w_lim) begin
        o_tc   = 1'b1;
        o_next = (i_mode == MODE_WRAP && i_is_up) ? '0 : i_limit;
      end else if (i_mode == MODE_SAT) begin
        if (i_is_up) begin
          if (w_sum >= w_lim) begin
            o_next = i_limit;
            o_tc   = 1'b1;
          end else begin
            o_next = WIDTH'(w_sum);
          end
        end else begin
          if (w_s >= w_cur) begin
            o_next = '0;
            o_tc   = 1'b1;
          end else begin
            o_next = WIDTH'(w_cur - w_s);
          end
        end
      end else begin
        if (i_is_up) begin
          if (w_sum > w_lim) begin
            o_next = WIDTH'(w_sum - w_mod);
            o_tc   = 1'b1;
          end else begin
            o_next = WIDTH'(w_sum);
          end
        end else begin
          if (w_s > w_cur) begin
            o_next = WIDTH'(w_cur + w_room);
            o_tc   = 1'b1;
          end else begin
            o_next = WIDTH'(w_cur - w_s);
          end
        end
      end
    end
  end

endmodule

// File: rtl/ubc_param.sv
// rtl/ubc_param.sv - modulus/step up-down counter; UBC_SAT_EN adds the sat port and saturate mode
module ubc_param
  import ubc_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STEP_W = DEFAULT_STEP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              isUp,
  input  logic              load,
  input  logic [WIDTH-1:0]  in,
  input  logic [WIDTH-1:0]  limit,
  input  logic [STEP_W-1:0] step,
`ifdef UBC_SAT_EN
  input  logic              sat,
`endif
  output logic [WIDTH-1:0]  out,
  output logic              tc,
  output logic              zero,
  output logic              at_max
);

  logic [WIDTH-1:0] r_out;
  logic             r_tc;
  logic [WIDTH-1:0] w_next;
  logic             w_tc;
  logic [WIDTH-1:0] w_load_val;
  ubc_mode_e        w_mode;

`ifdef UBC_SAT_EN
  assign w_mode = sat ? MODE_SAT : MODE_WRAP;
`else
  assign w_mode = MODE_WRAP;
`endif

  assign w_load_val = (in > limit) ? limit : in;

  ubc_step_unit #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_step (
    .i_out   (r_out),
    .i_limit (limit),
    .i_step  (step),
    .i_is_up (isUp),
    .i_mode  (w_mode),
    .o_next  (w_next),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out <= '0;
      r_tc  <= 1'b0;
    end else if (load) begin
      r_out <= w_load_val;
      r_tc  <= 1'b0;
    end else if (enable) begin
      r_out <= w_next;
      r_tc  <= w_tc;
    end else begin
      r_tc  <= 1'b0;
    end
  end

  assign out    = r_out;
  assign tc     = r_tc;
  assign zero   = (r_out == '0);
  assign at_max = (r_out == limit);

endmodule
